// File: rtl/irq_defs.sv
// Shared definitions for the interrupt request arbiter: FSM encodings and defaults.
package irq_defs;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_IN_SERVICE = 2'd2
    } irq_state_t;

    // Register used by the ISR return jump (jalr x30); the decoder raises isr_return on it.
    localparam logic [4:0]  ISR_RET_REG     = 5'd30;

    localparam int unsigned NUM_SRC_DEFAULT = 8;
    localparam int unsigned ID_W_DEFAULT    = 3;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser with rising-edge detector on the synchronised level.
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic synced,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus one history flop for the edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise_c = synced & ~prev_q;

endmodule

// File: rtl/interrupt_request_arbiter.sv
// Latches, masks and prioritises interrupt sources; issues one non-nested request at a time.
module interrupt_request_arbiter
    import irq_defs::*;
#(
    parameter int unsigned          NUM_SRC     = NUM_SRC_DEFAULT,
    parameter int unsigned          ID_W        = ID_W_DEFAULT,
    parameter logic [NUM_SRC-1:0]   EDGE_SRC    = '1,
    parameter int unsigned          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               mask_wr_en,
    input  logic [NUM_SRC-1:0] mask_wr_data,
    input  logic               isr_return,
    output logic               irq_out,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] irq_pending,
    output logic               in_service
);

    irq_state_t         state_q, state_d;
    logic [NUM_SRC-1:0] irq_mask_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] synced, rise_c;
    logic [NUM_SRC-1:0] req_c, clr_c;
    logic [ID_W-1:0]    winner_c, irq_id_d;

    // Lowest set index wins.
    function automatic logic [ID_W-1:0] prio_enc(input logic [NUM_SRC-1:0] v);
        prio_enc = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (v[i]) prio_enc = ID_W'(i);
        end
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .reset    (reset),
            .async_in (irq_src[i]),
            .synced   (synced[i]),
            .rise_c   (rise_c[i])
        );
    end

    assign req_c    = pending_q & irq_mask_q;
    assign winner_c = prio_enc(req_c);

    // Next state, grant capture and pending clear for the granted edge source.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id;
        clr_c    = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req_c) begin
                    state_d         = ST_ISSUE;
                    irq_id_d        = winner_c;
                    clr_c[winner_c] = 1'b1;
                end
            end
            ST_ISSUE:      state_d = ST_IN_SERVICE;
            ST_IN_SERVICE: if (isr_return) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Edge sources latch (a new edge beats a same-cycle clear); level sources follow the synced line.
    always_comb begin
        pending_d = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pending_d[i] = EDGE_SRC[i] ? ((pending_q[i] & ~clr_c[i]) | rise_c[i]) : synced[i];
        end
    end

    // State, mask, pending and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            irq_mask_q <= '0;
            pending_q  <= '0;
            irq_out    <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (mask_wr_en) irq_mask_q <= mask_wr_data;
            pending_q  <= pending_d;
            irq_out    <= (state_d == ST_ISSUE);
            irq_id     <= irq_id_d;
            in_service <= (state_d != ST_IDLE);
        end
    end

    assign irq_pending = pending_q;

endmodule

// File: tb/tb_interrupt_request_arbiter.sv
// Self-checking bench: directed scenarios followed by random traffic against a reference model.
module tb_interrupt_request_arbiter;

    localparam int unsigned NUM  = 8;
    localparam int unsigned IDW  = 3;
    localparam int unsigned SYNC = 2;
    localparam logic [7:0]  EDGE = 8'hEF;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NUM-1:0] irq_src = '0;
    logic           mask_wr_en = 1'b0;
    logic [NUM-1:0] mask_wr_data = '0;
    logic           isr_return = 1'b0;
    logic           irq_out;
    logic [IDW-1:0] irq_id;
    logic [NUM-1:0] irq_pending;
    logic           in_service;

    int n_vec = 0;
    int n_err = 0;

    interrupt_request_arbiter #(
        .NUM_SRC     (NUM),
        .ID_W        (IDW),
        .EDGE_SRC    (EDGE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_src      (irq_src),
        .mask_wr_en   (mask_wr_en),
        .mask_wr_data (mask_wr_data),
        .isr_return   (isr_return),
        .irq_out      (irq_out),
        .irq_id       (irq_id),
        .irq_pending  (irq_pending),
        .in_service   (in_service)
    );

    always #5 clk = ~clk;

    // Reference model: input history, mask, pending, and "busy with a grant" status.
    logic [NUM-1:0] hist[$];
    logic [NUM-1:0] m_mask = '0, m_pend = '0;
    logic           m_out = 1'b0, m_busy = 1'b0;
    logic [IDW-1:0] m_id = '0;

    function automatic logic [NUM-1:0] hist_at(input int k);
        if (k < 0 || k >= hist.size()) return '0;
        return hist[k];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [NUM-1:0] lvl, prv, rise, req, pend_n;
        logic           grant;
        int             win;
        if (reset) begin
            hist.delete();
            m_mask = '0; m_pend = '0; m_out = 1'b0; m_busy = 1'b0; m_id = '0;
            return;
        end
        hist.push_back(irq_src);
        if (hist.size() > SYNC + 2) void'(hist.pop_front());
        lvl  = hist_at(hist.size() - 1 - SYNC);
        prv  = hist_at(hist.size() - 2 - SYNC);
        rise = lvl & ~prv;
        req  = m_pend & m_mask;
        win  = -1;
        for (int i = 0; i < NUM; i++) if (req[i] && win < 0) win = i;
        grant = !m_busy && (win >= 0);
        for (int i = 0; i < NUM; i++) begin
            if (EDGE[i]) pend_n[i] = (m_pend[i] && !(grant && win == i)) || rise[i];
            else         pend_n[i] = lvl[i];
        end
        m_busy = grant || (m_busy && !(isr_return && !m_out));
        if (grant) m_id = IDW'(win);
        m_out  = grant;
        m_pend = pend_n;
        if (mask_wr_en) m_mask = mask_wr_data;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("irq_out", 32'(irq_out), 32'(m_out));
            chk("irq_id", 32'(irq_id), 32'(m_id));
            chk("irq_pending", 32'(irq_pending), 32'(m_pend));
            chk("in_service", 32'(in_service), 32'(m_busy));
            mask_wr_en = 1'b0;
            isr_return = 1'b0;
        end
    endtask

    task automatic set_mask(input logic [NUM-1:0] m);
        mask_wr_en = 1'b1; mask_wr_data = m; step(1);
    endtask

    task automatic do_return();
        isr_return = 1'b1; step(1);
    endtask

    int cnt;

    initial begin
        #1;
        step(2);
        chk("rst_out", 32'(irq_out), 32'd0);
        chk("rst_pend", 32'(irq_pending), 32'd0);
        reset = 1'b0;

        // 1: single edge source, latency and clear on issue
        set_mask(8'h08);
        irq_src[3] = 1'b1; step(3);
        chk("t1_pend", 32'(irq_pending[3]), 32'd1);
        chk("t1_noirq", 32'(irq_out), 32'd0);
        step(1);
        chk("t1_irq", 32'(irq_out), 32'd1);
        chk("t1_id", 32'(irq_id), 32'd3);
        chk("t1_insvc", 32'(in_service), 32'd1);
        chk("t1_clr", 32'(irq_pending[3]), 32'd0);
        step(2); do_return();
        chk("t1_ret", 32'(in_service), 32'd0);
        irq_src = '0; step(4);

        // 2: simultaneous edges, lowest index first, back-to-back after return
        set_mask(8'hFF);
        irq_src[5] = 1'b1; irq_src[2] = 1'b1; step(4);
        chk("t2_irq_a", 32'(irq_out), 32'd1);
        chk("t2_id_a", 32'(irq_id), 32'd2);
        step(1); do_return();
        chk("t2_gap", 32'(irq_out), 32'd0);
        step(1);
        chk("t2_irq_b", 32'(irq_out), 32'd1);
        chk("t2_id_b", 32'(irq_id), 32'd5);
        step(1); do_return();
        irq_src = '0; step(4);

        // 3: masked source holds pending; unmask releases it two cycles later
        set_mask(8'h00);
        irq_src[1] = 1'b1; step(5);
        chk("t3_pend", 32'(irq_pending[1]), 32'd1);
        chk("t3_noirq", 32'(irq_out), 32'd0);
        set_mask(8'h02);
        chk("t3_wait", 32'(irq_out), 32'd0);
        step(1);
        chk("t3_irq", 32'(irq_out), 32'd1);
        chk("t3_id", 32'(irq_id), 32'd1);
        step(1); do_return();
        irq_src = '0; step(4);

        // 4: repeated edges while in service collapse to one further request
        set_mask(8'hFF);
        irq_src[0] = 1'b1; step(4);
        chk("t4_irq", 32'(irq_out), 32'd1);
        irq_src[0] = 1'b0; step(2); irq_src[0] = 1'b1; step(2);
        irq_src[0] = 1'b0; step(2); irq_src[0] = 1'b1; step(4);
        do_return();
        cnt = 0;
        repeat (10) begin step(1); cnt += int'(irq_out); end
        chk("t4_count", 32'(cnt), 32'd1);
        do_return(); step(3);
        do_return();
        chk("t4_idle_ret", 32'(in_service), 32'd0);
        step(2);
        chk("t4_idle_irq", 32'(irq_out), 32'd0);
        irq_src = '0; step(4);

        // 5: level source re-issues while held; a drop before issue produces nothing
        irq_src[4] = 1'b1; step(4);
        chk("t5_id_a", 32'(irq_id), 32'd4);
        step(2); do_return(); step(1);
        chk("t5_reissue", 32'(irq_out), 32'd1);
        chk("t5_id_b", 32'(irq_id), 32'd4);
        step(1); irq_src[4] = 1'b0; do_return(); step(1);
        set_mask(8'h00); step(4);
        irq_src[4] = 1'b1; step(4);
        chk("t5_lvl_pend", 32'(irq_pending[4]), 32'd1);
        irq_src[4] = 1'b0; step(4);
        set_mask(8'hFF);
        cnt = 0;
        repeat (6) begin step(1); cnt += int'(irq_out); end
        chk("t5_none", 32'(cnt), 32'd0);

        // 6: reset during service discards everything
        irq_src[0] = 1'b1; irq_src[4] = 1'b1; step(4);
        irq_src[0] = 1'b0; step(2); irq_src[0] = 1'b1; step(4);
        chk("t6_pend", 32'(irq_pending), 32'h11);
        chk("t6_insvc", 32'(in_service), 32'd1);
        reset = 1'b1; irq_src = '0; step(1);
        chk("t6_rst_pend", 32'(irq_pending), 32'd0);
        chk("t6_rst_svc", 32'(in_service), 32'd0);
        reset = 1'b0;
        set_mask(8'hFF);
        cnt = 0;
        repeat (6) begin step(1); cnt += int'(irq_out); end
        chk("t6_quiet", 32'(cnt), 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM; i++) if ($urandom_range(15) == 0) irq_src[i] = ~irq_src[i];
            if ($urandom_range(31) == 0) begin
                mask_wr_en = 1'b1; mask_wr_data = NUM'($urandom);
            end
            isr_return = ($urandom_range(5) == 0);
            reset = ($urandom_range(499) == 0);
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

endmodule
